// File: rtl/reaction_timer_core.sv
// Reaction timer core: after a start press, waits a pseudo-random delay,
// lights the stimulus LED and counts elapsed milliseconds in BCD (s.sss)
// until the reaction press. Flags false starts and counter overflow.
module reaction_timer_core #(
    parameter int TICK_DIV   = 50000,
    parameter int DELAY_BASE = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_btn,
    input  logic       react_btn,
    output logic [2:0] state,
    output logic       led,
    output logic [3:0] ones,
    output logic [3:0] tenths,
    output logic [3:0] hundreths,
    output logic [3:0] thousandths
);

    // State codes are visible on the state port and decoded downstream.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_DELAY = 3'd2;
    localparam logic [2:0] ST_COUNT = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_FAULT = 3'd5;

    localparam int          PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int BTN_START = 0;
    localparam int BTN_REACT = 1;

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic [1:0] btn_in;
    logic [1:0] btn_meta_q,  btn_meta_d;
    logic [1:0] btn_sync_q,  btn_sync_d;
    logic [1:0] btn_prev_q,  btn_prev_d;
    logic [1:0] btn_armed_q, btn_armed_d;
    logic [1:0] fill_q,      fill_d;
    logic [1:0] btn_edge;
    logic       start_edge;
    logic       react_edge;

    assign btn_in = {react_btn, start_btn};

    // Synchronize both buttons, then detect a rising edge only once armed.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no
        // latch is inferred; later blocks follow the same default-first pattern.
        btn_meta_d  = btn_in;
        btn_sync_d  = btn_meta_q;
        btn_prev_d  = btn_sync_q;
        fill_d      = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
        // NOTE: the chain is reset to 0, so a button held through reset
        // would look like a fresh press once it propagates. A button is only
        // armed after the chain has filled with real samples and has shown
        // the button released; an edge is reported only from an armed button.
        btn_armed_d = btn_armed_q | ({2{fill_q == 2'd2}} & ~btn_sync_q);
        btn_edge    = btn_sync_q & ~btn_prev_q & btn_armed_q;
    end

    assign start_edge = btn_edge[BTN_START];
    assign react_edge = btn_edge[BTN_REACT];

    // NOTE: two flops in series give a metastable first stage a full cycle
    // to settle before anything downstream uses the button level.
    // Button synchronizer, edge history and arming flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta_q  <= '0;
            btn_sync_q  <= '0;
            btn_prev_q  <= '0;
            btn_armed_q <= '0;
            fill_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, which is what turns this into a shift chain.
            btn_meta_q  <= btn_meta_d;
            btn_sync_q  <= btn_sync_d;
            btn_prev_q  <= btn_prev_d;
            btn_armed_q <= btn_armed_d;
            fill_q      <= fill_d;
        end
    end

    // ------------------------------------------------------------------
    // Free-running pseudo-random source
    // ------------------------------------------------------------------
    logic [15:0] lfsr_q, lfsr_d;

    // Advance the Galois LFSR one step every cycle.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    // LFSR register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // ------------------------------------------------------------------
    // Millisecond prescaler
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick;
    logic               presc_clr;

    // Count 0..TICK_DIV-1, tick on the last count; the FSM can restart it.
    always_comb begin
        tick    = (presc_q == PRESC_W'(TICK_DIV - 1));
        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
        if (presc_clr) begin
            presc_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // ------------------------------------------------------------------
    // BCD elapsed-time counter helpers
    // ------------------------------------------------------------------
    // Digit 0 is thousandths (least significant), digit 3 is ones.
    logic [3:0][3:0] digits_q, digits_d;
    logic [3:0][3:0] digits_inc;
    logic            digits_full;

    // Ripple a +1 through the four BCD digits; detect 9.999 s.
    always_comb begin
        logic carry;
        carry      = 1'b1;
        digits_inc = digits_q;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (digits_q[i] == 4'd9) begin
                    digits_inc[i] = 4'd0;
                end else begin
                    digits_inc[i] = digits_q[i] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        digits_full = (digits_q == {4{4'd9}});
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic [2:0]  state_q, state_d;
    logic        led_q,   led_d;
    logic [10:0] delay_q, delay_d;
    logic [10:0] delay_load;

    assign delay_load = 11'(DELAY_BASE) + 11'(lfsr_q[9:0]);

    // Next state, digit and delay-counter decisions.
    always_comb begin
        state_d   = state_q;
        digits_d  = digits_q;
        delay_d   = delay_q;
        presc_clr = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                // Reaction presses are meaningless while waiting for a start.
                if (start_edge) begin
                    state_d   = ST_LOAD;
                    digits_d  = '0;
                    delay_d   = delay_load;
                    presc_clr = 1'b1;
                end
            end

            ST_LOAD: begin
                state_d   = ST_DELAY;
                presc_clr = 1'b1;
            end

            ST_DELAY: begin
                if (react_edge) begin
                    // Pressed before the LED lit: false start.
                    state_d  = ST_FAULT;
                    digits_d = '0;
                end else if (tick) begin
                    if (delay_q <= 11'd1) begin
                        state_d   = ST_COUNT;
                        delay_d   = '0;
                        presc_clr = 1'b1;
                    end else begin
                        delay_d = delay_q - 11'd1;
                    end
                end
            end

            ST_COUNT: begin
                // A reaction in the same cycle as a tick wins: the time shown
                // is the last whole millisecond before the press.
                if (react_edge) begin
                    state_d = ST_DONE;
                end else if (tick) begin
                    if (digits_full) begin
                        state_d = ST_FAULT;
                    end else begin
                        digits_d = digits_inc;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        led_d = (state_d == ST_COUNT);
    end

    // FSM, LED, digit and delay-counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            led_q    <= 1'b0;
            digits_q <= '0;
            delay_q  <= '0;
        end else begin
            state_q  <= state_d;
            led_q    <= led_d;
            digits_q <= digits_d;
            delay_q  <= delay_d;
        end
    end

    assign state       = state_q;
    assign led         = led_q;
    assign ones        = digits_q[3];
    assign tenths      = digits_q[2];
    assign hundreths   = digits_q[1];
    assign thousandths = digits_q[0];

endmodule

// File: tb/tb_reaction_timer_core.sv
// Bench for reaction_timer_core: directed scenarios plus randomized rounds,
// every cycle compared against a millisecond-level behavioural model.
module tb_reaction_timer_core;

    localparam int TD = 4;
    localparam int DB = 2;

    localparam int S_IDLE  = 0;
    localparam int S_LOAD  = 1;
    localparam int S_DELAY = 2;
    localparam int S_COUNT = 3;
    localparam int S_DONE  = 4;
    localparam int S_FAULT = 5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start_btn;
    logic       react_btn;
    logic [2:0] state;
    logic       led;
    logic [3:0] ones, tenths, hundreths, thousandths;

    always #5 clk = ~clk;

    reaction_timer_core #(
        .TICK_DIV   (TD),
        .DELAY_BASE (DB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_btn   (start_btn),
        .react_btn   (react_btn),
        .state       (state),
        .led         (led),
        .ones        (ones),
        .tenths      (tenths),
        .hundreths   (hundreths),
        .thousandths (thousandths)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
            if (n_checks - n_pass >= 50) begin
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $finish;
            end
        end
    endtask

    // ---------------- behavioural model ----------------
    // Elapsed time kept as an integer number of ms; button edges derived
    // from the recent sample history (a press is seen two samples after
    // the first high sample, provided the sample before it was low).
    int          m_state;
    int          m_count;
    int          m_delay;
    int          m_presc;
    logic [15:0] m_lfsr;
    bit          hs[$];
    bit          hr[$];
    bit          led_seen;

    function automatic logic [15:0] bcd(input int c);
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    task automatic model_reset();
        m_state = S_IDLE;
        m_count = 0;
        m_delay = 0;
        m_presc = 0;
        m_lfsr  = 16'hACE1;
        // Unknown pre-reset history counts as "held": no edge until a low.
        hs = '{1'b1, 1'b1, 1'b1};
        hr = '{1'b1, 1'b1, 1'b1};
    endtask

    task automatic model_edge();
        bit se, re, tick;
        int nxt_presc, load;
        se = hs[1] && !hs[2];
        re = hr[1] && !hr[2];
        hs.push_front(start_btn);
        void'(hs.pop_back());
        hr.push_front(react_btn);
        void'(hr.pop_back());
        tick      = (m_presc == TD - 1);
        nxt_presc = tick ? 0 : m_presc + 1;
        load      = DB + int'(m_lfsr % 16'd1024);
        case (m_state)
            S_IDLE, S_DONE, S_FAULT: if (se) begin
                m_state = S_LOAD; m_count = 0; m_delay = load; nxt_presc = 0;
            end
            S_LOAD: begin
                m_state = S_DELAY; nxt_presc = 0;
            end
            S_DELAY: if (re) begin
                m_state = S_FAULT;
            end else if (tick) begin
                m_delay = m_delay - 1;
                if (m_delay <= 0) begin
                    m_state = S_COUNT; nxt_presc = 0;
                end
            end
            S_COUNT: if (re) begin
                m_state = S_DONE;
            end else if (tick) begin
                if (m_count == 9999) m_state = S_FAULT;
                else m_count = m_count + 1;
            end
            default: m_state = S_IDLE;
        endcase
        m_presc = nxt_presc;
        m_lfsr  = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [15:0] digits();
        return {ones, tenths, hundreths, thousandths};
    endfunction

    task automatic step();
        logic [19:0] got, exp;
        @(posedge clk);
        model_edge();
        #1;
        if (led) led_seen = 1'b1;
        got = {state, led, digits()};
        exp = {3'(m_state), (m_state == S_COUNT), bcd(m_count)};
        check("cycle", 32'(got), 32'(exp));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_start(input int w);
        start_btn = 1'b1;
        run(w);
        start_btn = 1'b0;
    endtask

    task automatic pulse_react(input int w);
        react_btn = 1'b1;
        run(w);
        react_btn = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget, input string tag);
        int k = 0;
        while (m_state != s && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    // Stop in COUNT at the given ms value; with align set, also at the
    // prescaler phase where a press made now lands exactly on a tick.
    task automatic wait_count(input int target, input bit align, input int budget,
                              input string tag);
        int k = 0;
        while (!(m_state == S_COUNT && m_count == target &&
                 (!align || m_presc == TD - 3)) && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(digits()), 32'(bcd(target)));
    endtask

    int targets[4] = '{0, 1, 2, 4};

    initial begin
        reset_n   = 1'b0;
        start_btn = 1'b0;
        react_btn = 1'b0;
        led_seen  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(state), 32'(S_IDLE));
        check("reset_led", 32'(led), 32'h0);
        check("reset_digits", 32'(digits()), 32'h0);
        #3 reset_n = 1'b1;
        model_reset();
        run(6);

        // Start: A -> B -> C, LED dark.
        check("idle_hold", 32'(state), 32'(S_IDLE));
        pulse_start(1);
        wait_state(S_LOAD, 10, "to_load");
        step();
        check("to_delay", 32'(state), 32'(S_DELAY));
        check("delay_led", 32'(led), 32'h0);

        // Normal reaction after 37 ms.
        wait_state(S_COUNT, 5000, "to_count");
        check("count_led", 32'(led), 32'h1);
        wait_count(37, 1'b1, 1000, "at_37");
        pulse_react(1);
        wait_state(S_DONE, 6, "to_done");
        check("done_digits", 32'(digits()), 32'h0037);
        check("done_led", 32'(led), 32'h0);
        run(100 * TD);
        check("done_stable", 32'(digits()), 32'h0037);
        check("done_state_stable", 32'(state), 32'(S_DONE));

        // False start during the delay.
        led_seen = 1'b0;
        pulse_start(2);
        wait_state(S_DELAY, 10, "fs_delay");
        pulse_react(1);
        wait_state(S_FAULT, 6, "false_start");
        check("fs_digits", 32'(digits()), 32'h0);
        pulse_react(2);
        run(5);
        check("fault_react_ignored", 32'(state), 32'(S_FAULT));
        check("fs_led_never", 32'(led_seen), 32'h0);

        // Overflow at 9.999 s.
        pulse_start(1);
        wait_state(S_COUNT, 5000, "ovf_count");
        wait_count(9999, 1'b0, 9999 * TD + 20, "at_9999");
        wait_state(S_FAULT, 2 * TD + 4, "overflow");
        check("ovf_digits", 32'(digits()), 32'h9999);
        run(3 * TD);
        check("ovf_hold", 32'(digits()), 32'h9999);

        // Reaction coincident with a tick: no increment; start ignored in D.
        for (int i = 0; i < 4; i++) begin
            pulse_start(1);
            wait_state(S_COUNT, 5000, "tie_count");
            if (i == 3) begin
                pulse_start(1);
                run(TD);
                check("start_in_count", 32'(state), 32'(S_COUNT));
            end
            wait_count(targets[i], 1'b1, 100, "tie_align");
            pulse_react(1);
            wait_state(S_DONE, 6, "tie_done");
            check("tie_digits", 32'(digits()), 32'(bcd(targets[i])));
        end

        // Reset mid-count at 0.500 s, with start held through reset release.
        pulse_start(1);
        wait_state(S_COUNT, 5000, "rst_count");
        wait_count(500, 1'b0, 500 * TD + 20, "at_500");
        run(1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_state", 32'(state), 32'(S_IDLE));
        check("midrst_led", 32'(led), 32'h0);
        check("midrst_digits", 32'(digits()), 32'h0);
        start_btn = 1'b1;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        model_reset();
        run(10);
        check("held_start_ignored", 32'(state), 32'(S_IDLE));
        start_btn = 1'b0;
        run(3);
        pulse_start(1);
        wait_state(S_LOAD, 10, "post_rst_load");
        step();
        check("post_rst_delay", 32'(state), 32'(S_DELAY));

        // Randomized rounds.
        for (int r = 0; r < 3; r++) begin
            int mode;
            int k;
            mode = $urandom_range(0, 2);
            pulse_start($urandom_range(1, 3));
            wait_state(S_DELAY, 12, "rnd_delay");
            if (mode == 0) begin
                run($urandom_range(0, 5));
                pulse_react($urandom_range(1, 3));
            end else begin
                wait_state(S_COUNT, 5000, "rnd_count");
                if (mode == 2) pulse_start($urandom_range(1, 3));
                run($urandom_range(0, 40));
                pulse_react($urandom_range(1, 3));
            end
            k = 0;
            while (m_state != S_DONE && m_state != S_FAULT && k < 50) begin
                step();
                k++;
            end
            check("rnd_end", 32'(state), 32'(m_state));
            check("rnd_digits", 32'(digits()), 32'(bcd(m_count)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reaction_timer_core.md
REACTION_TIMER_CORE -- requirements
Module: reaction_timer_core

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, meaning clk cycles per 1 ms tick (50 MHz clk).
REQ-002 SHALL have parameter DELAY_BASE, default 1000, meaning minimum random delay in ms.
REQ-003 SHALL have port clk  input  1  sole clock; all flops rising-edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_btn  input  1  asynchronous start pushbutton, active-high.
REQ-006 SHALL have port react_btn  input  1  asynchronous reaction pushbutton, active-high.
REQ-007 SHALL have port state  output  3  FSM state code; feeds the downstream BCD display decoder.
REQ-008 SHALL have port led  output  1  stimulus LED, high only in state D.
REQ-009 SHALL have ports ones, tenths, hundreths, thousandths  output  4 each  BCD elapsed time, s.sss.

Function
REQ-010 SHALL pass start_btn and react_btn each through a 2-flop synchronizer plus a rising-edge detector; an edge pulse is 1 cycle, 3 cycles after the input rises.
REQ-011 SHALL run a free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) that advances every cycle.
REQ-012 SHALL use state encoding A=0 IDLE, B=1 LOAD, C=2 DELAY, D=3 COUNT, E=4 DONE, F=5 FAULT; codes 6-7 SHALL return to A next cycle.
REQ-013 A: start edge -> B; react edge ignored; digits held.
REQ-014 B (exactly 1 cycle):
  - clear all digits to 0;
  - load delay counter = DELAY_BASE + lfsr[9:0];
  - clear prescaler;
  - -> C.
REQ-015 C: decrement delay counter per ms tick.
  - react edge -> F, digits 0000 (false start);
  - delay counter reaches 0 on a tick -> D, prescaler cleared.
REQ-016 D: led=1; each ms tick increments the 4-digit BCD counter, with each digit wrapping 9->0 and carrying into the next.
REQ-017 D: react edge -> E, digits frozen; a react edge and a tick in the same cycle -> E without increment.
REQ-018 D: a tick with digits 9,9,9,9 -> F, digits held at 9999 (overflow, no wrap).
REQ-019 E and F: digits held; start edge -> B; react edge ignored.
REQ-020 Start edges SHALL be ignored in B, C and D.
REQ-021 Prescaler SHALL count 0..TICK_DIV-1 and assert a 1-cycle tick when it equals TICK_DIV-1, then wrap to 0; it SHALL be cleared on entry to C and to D.
REQ-022 All outputs SHALL be registered; state, led and digits update on the same edge as the transition.
REQ-023 Delay counter width SHALL be 11 bits; the maximum load is DELAY_BASE+1023 = 2023 at defaults.

Reset
REQ-024 reset_n low SHALL immediately force: state=A, led=0, all digits 0, prescaler 0, delay counter 0, synchronizers 0, LFSR=16'hACE1.
REQ-025 Reset asserted mid-operation (any state) SHALL abort to A with the values in REQ-024; no edge SHALL be detected from a button already held at reset release until it falls and rises again.

Verification (TICK_DIV=4, DELAY_BASE=2 for sim)
REQ-026 Release reset, pulse start_btn -> state sequence A->B->C; led=0; delay counter = 2+lfsr[9:0] at the B cycle.
REQ-027 Let delay expire, wait 37 ticks, pulse react_btn -> state E, digits 0,0,3,7, led=0, values stable through 100 further ticks.
REQ-028 Pulse react_btn during C -> state F, digits 0000, led never asserted.
REQ-029 Remain in D for 9999 ticks -> digits 9,9,9,9; the next tick -> state F, digits still 9999.
REQ-030 In D, align a react edge with a tick at count 0,1,2,4 -> E with digits 0,1,2,4 (no increment); start pulse in D -> no state change.
REQ-031 Assert reset_n low while in D at count 0,5,0,0 -> outputs immediately state=0, led=0, digits 0000; then start pulse -> normal B entry.
